uart_tx_scheduler: RTL

Shares one UART transmitter between NREQ byte requesters using round-robin arbitration. Latches the winning byte and pulses the transmitter start. Tracks the transmitter through busy and back to idle, then reports completion to the winning requester. Sits between the host-side producers (command responder, status reporter, debug port) and the transmit state machine/shifter.

---
 rtl/uart_tx_scheduler_pkg.sv | 16 +
 rtl/uart_tx_scheduler_rr_arbiter.sv | 32 +++
 rtl/uart_tx_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: state encodings and sizing helpers.
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    TXS_IDLE      = 3'd0,
    TXS_LAUNCH    = 3'd1,
    TXS_WAIT_ACK  = 3'd2,
    TXS_WAIT_DONE = 3'd3,
    TXS_GAP       = 3'd4
  } txs_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping mod NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  int pos;

  // Walk offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    pos   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req[IDX_W'(pos)]) begin
        index = IDX_W'(pos);
        valid = 1'b1;
      end
    end
    if (valid) grant[index] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NREQ byte requesters with round-robin arbitration,
// start/ack handshake, completion reporting and an inter-frame gap.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 8,
  parameter int GAP_CYCLES  = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ*DATA_W-1:0] DATA,
  output logic [NREQ-1:0]        GNT,
  output logic [DATA_W-1:0]      TX_DATA,
  output logic                   TX_START,
  input  logic                   TX_BUSY,
  output logic                   DONE,
  output logic [2:0]             DONE_ID,
  output logic                   ERR,
  output logic                   BUSY
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(max_int(ACK_TIMEOUT, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  txs_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] win_index;
  logic [NREQ-1:0]  win_grant;
  logic             win_valid;
  logic [2:0]       owner;
  logic [CNT_W-1:0] cnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (REQ),
    .ptr   (ptr),
    .grant (win_grant),
    .index (win_index),
    .valid (win_valid)
  );

  assign next_ptr = (int'(win_index) == NREQ - 1) ? '0 : win_index + 1'b1;

  // Pulses default low every cycle; each state raises at most one of them.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= TXS_IDLE;
      GNT      <= '0;
      TX_DATA  <= '0;
      TX_START <= 1'b0;
      DONE     <= 1'b0;
      DONE_ID  <= '0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
    end else begin
      GNT      <= '0;
      TX_START <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      case (state)
        TXS_IDLE: begin
          if (win_valid && !TX_BUSY) begin
            GNT     <= win_grant;
            TX_DATA <= DATA[int'(win_index)*DATA_W +: DATA_W];
            owner   <= 3'(win_index);
            ptr     <= next_ptr;
            cnt     <= '0;
            BUSY    <= 1'b1;
            state   <= TXS_LAUNCH;
          end
        end
        TXS_LAUNCH: begin
          TX_START <= 1'b1;
          cnt      <= '0;
          state    <= TXS_WAIT_ACK;
        end
        TXS_WAIT_ACK: begin
          if (TX_BUSY) begin
            cnt   <= '0;
            state <= TXS_WAIT_DONE;
          end else if (cnt == ACK_LAST) begin
            ERR     <= 1'b1;
            DONE_ID <= owner;
            cnt     <= '0;
            BUSY    <= 1'b0;
            state   <= TXS_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TXS_WAIT_DONE: begin
          if (!TX_BUSY) begin
            DONE    <= 1'b1;
            DONE_ID <= owner;
            cnt     <= '0;
            if (GAP_CYCLES > 0) begin
              state <= TXS_GAP;
            end else begin
              BUSY  <= 1'b0;
              state <= TXS_IDLE;
            end
          end
        end
        TXS_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            BUSY  <= 1'b0;
            state <= TXS_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          BUSY  <= 1'b0;
          state <= TXS_IDLE;
        end
      endcase
    end
  end

endmodule
